// File: rtl/sha256_msg_host.sv
// rtl/sha256_msg_host.sv - host-side word RAM, SHA-256 padder and memory responder for simplified_sha256
//
// Purpose:
//   Collects NUM_OF_WORDS message words from a valid/ready stream into an
//   internal word RAM at INPUT_ADDR, appends SHA-256 padding in place, starts
//   the hash core and serves its memory reads/writes.  When the core reports
//   done, the 8 hash words at HASH_ADDR are streamed out on a second
//   valid/ready stream.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   in_valid/in_ready/in_data     message word stream (big-endian word order)
//   out_valid/out_ready/out_data  hash word stream, H0 first
//   out_last                      marks the 8th hash word
//   busy                          high whenever the FSM is not IDLE
//   core_start                    start request to the core
//   core_done                     core idle/done indication
//   core_addr/core_we/core_wdata  core memory access
//   core_rdata                    registered read data (1-cycle latency)
//   input_addr/hash_addr          constant base addresses for the core

module sha256_msg_host #(
    parameter int          NUM_OF_WORDS = 40,
    parameter int          MEM_DEPTH    = 128,
    parameter logic [15:0] INPUT_ADDR   = 16'd0,
    parameter logic [15:0] HASH_ADDR    = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        core_start,
    input  logic        core_done,
    input  logic [15:0] core_addr,
    input  logic        core_we,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic [15:0] input_addr,
    output logic [15:0] hash_addr
);

    // Number of 512-bit blocks: message + 0x80000000 word + 64-bit length.
    localparam int          NB       = (NUM_OF_WORDS + 3 + 15) / 16;
    localparam logic [15:0] LAST_MSG = 16'(NUM_OF_WORDS - 1);
    localparam logic [15:0] MSG_LEN  = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_PAD = 16'(16 * NB - 1);
    localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);
    localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0] DEPTH17  = 17'(MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        UNLOAD
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  ucnt;

    logic [31:0] mem [0:MEM_DEPTH-1];

    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] hash_rd_addr;
    logic [31:0] hash_word;

    // Addresses beyond the RAM read as zero and swallow writes.
    function automatic logic addr_ok(input logic [15:0] a);
        return ({1'b0, a} < DEPTH17);
    endfunction

    assign input_addr = INPUT_ADDR;
    assign hash_addr  = HASH_ADDR;
    assign busy       = (state != IDLE);
    assign in_ready   = (state == IDLE) || (state == LOAD);

    // Single RAM write port shared by the loader, the padder and the core.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = 16'd0;
        wr_data = 32'd0;
        case (state)
            IDLE, LOAD: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = INPUT_ADDR + cnt;
                    wr_data = in_data;
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_addr = INPUT_ADDR + cnt;
                if (cnt == MSG_LEN)
                    wr_data = 32'h8000_0000;
                else if (cnt == LAST_PAD)
                    wr_data = LEN_BITS;
                else
                    wr_data = 32'd0;
            end
            WAIT_BUSY, WAIT_DONE: begin
                if (core_we) begin
                    wr_en   = 1'b1;
                    wr_addr = core_addr;
                    wr_data = core_wdata;
                end
            end
            default: ;
        endcase
    end

    // RAM contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst && addr_ok(wr_addr))
            mem[wr_addr[AW-1:0]] <= wr_data;
    end

    // Core read port runs every cycle; the non-blocking write above means a
    // same-address read in the write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (rst)
            core_rdata <= 32'd0;
        else
            core_rdata <= addr_ok(core_addr) ? mem[core_addr[AW-1:0]] : 32'd0;
    end

    assign hash_rd_addr = HASH_ADDR + {12'd0, ucnt};
    assign hash_word    = addr_ok(hash_rd_addr) ? mem[hash_rd_addr[AW-1:0]] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            ucnt       <= 4'd0;
            core_start <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= 32'd0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + 16'd1;
                        state <= (cnt == LAST_MSG) ? PAD : LOAD;
                    end
                end
                PAD: begin
                    if (cnt == LAST_PAD) begin
                        cnt        <= 16'd0;
                        core_start <= 1'b1;
                        state      <= START;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Hold the start request until the core shows it is busy.
                    if (!core_done) begin
                        core_start <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (core_done) begin
                        ucnt  <= 4'd0;
                        state <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    // Output register advances only when empty or being taken,
                    // so data/last stay frozen under backpressure.
                    if (!out_valid || out_ready) begin
                        if (out_valid && out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else if (ucnt < 4'd8) begin
                            out_data  <= hash_word;
                            out_valid <= 1'b1;
                            out_last  <= (ucnt == 4'd7);
                            ucnt      <= ucnt + 4'd1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_host.sv
// tb/tb_sha256_msg_host.sv - directed self-checking bench for sha256_msg_host

module tb_sha256_msg_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        core_done;
    logic [15:0] core_addr;
    logic        core_we;
    logic [31:0] core_wdata;

    logic        in_ready, out_valid, out_last, busy, core_start;
    logic [31:0] out_data, core_rdata;
    logic [15:0] input_addr, hash_addr;

    logic        in_ready13, out_valid13, out_last13, busy13, core_start13;
    logic [31:0] out_data13, core_rdata13;
    logic [15:0] input_addr13, hash_addr13;

    logic        in_ready14, out_valid14, out_last14, busy14, core_start14;
    logic [31:0] out_data14, core_rdata14;
    logic [15:0] input_addr14, hash_addr14;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sha256_msg_host #(.NUM_OF_WORDS(40)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .core_start(core_start), .core_done(core_done), .core_addr(core_addr),
        .core_we(core_we), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .input_addr(input_addr), .hash_addr(hash_addr)
    );

    sha256_msg_host #(.NUM_OF_WORDS(13)) dut13 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready13), .in_data(in_data),
        .out_valid(out_valid13), .out_ready(out_ready), .out_data(out_data13), .out_last(out_last13),
        .busy(busy13), .core_start(core_start13), .core_done(core_done), .core_addr(core_addr),
        .core_we(core_we), .core_wdata(core_wdata), .core_rdata(core_rdata13),
        .input_addr(input_addr13), .hash_addr(hash_addr13)
    );

    sha256_msg_host #(.NUM_OF_WORDS(14)) dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready14), .in_data(in_data),
        .out_valid(out_valid14), .out_ready(out_ready), .out_data(out_data14), .out_last(out_last14),
        .busy(busy14), .core_start(core_start14), .core_done(core_done), .core_addr(core_addr),
        .core_we(core_we), .core_wdata(core_wdata), .core_rdata(core_rdata14),
        .input_addr(input_addr14), .hash_addr(hash_addr14)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input int which, input logic [15:0] a, input logic [31:0] exp);
        core_addr = a;
        tick();
        case (which)
            13:      check($sformatf("n13_mem[%0d]", a), core_rdata13, exp);
            14:      check($sformatf("n14_mem[%0d]", a), core_rdata14, exp);
            default: check($sformatf("mem[%0d]", a), core_rdata, exp);
        endcase
    endtask

    task automatic load_words(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base | 32'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 60 && !core_start; i++) tick();
        check(tag, {31'd0, core_start}, 32'd1);
    endtask

    logic [3:0] pat;
    int beat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_done = 1'b1; core_addr = '0; core_we = 1'b0; core_wdata = '0;
        pat = 4'b1001;

        // 1: reset state
        tick(); tick();
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("input_addr", {16'd0, input_addr}, 32'd0);
        check("hash_addr", {16'd0, hash_addr}, 32'd64);

        // 2 + 5b: 40-word load with a stalled cycle carrying core_we
        load_words(10, 32'd0);
        core_we = 1'b1; core_addr = 16'd3; core_wdata = 32'hDEAD_BEEF;
        tick();
        core_we = 1'b0;
        check("load_busy", {31'd0, busy}, 32'd1);
        for (int k = 10; k < 40; k++) begin
            in_valid = 1'b1;
            in_data  = 32'(k);
            tick();
        end
        in_valid = 1'b0;
        check("pad_in_ready", {31'd0, in_ready}, 32'd0);
        wait_start("n40_core_start");
        peek(40, 16'd0,  32'd0);
        peek(40, 16'd3,  32'd3);
        peek(40, 16'd39, 32'h27);
        peek(40, 16'd40, 32'h8000_0000);
        for (int a = 41; a <= 46; a++) peek(40, 16'(a), 32'd0);
        peek(40, 16'd47, 32'h500);
        check("start_held", {31'd0, core_start}, 32'd1);

        // 3: padding boundaries
        peek(13, 16'd12, 32'd12);
        peek(13, 16'd13, 32'h8000_0000);
        peek(13, 16'd14, 32'd0);
        peek(13, 16'd15, 32'h1A0);
        peek(14, 16'd14, 32'h8000_0000);
        peek(14, 16'd15, 32'd0);
        peek(14, 16'd30, 32'd0);
        peek(14, 16'd31, 32'h1C0);

        // 4/5: core goes busy, writes hash, reads back
        core_done = 1'b0;
        tick();
        check("start_drop", {31'd0, core_start}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            core_we = 1'b1; core_addr = 16'(64 + k - 1); core_wdata = 32'h1111_1111 * 32'(k);
            tick();
        end
        core_we = 1'b0;
        peek(40, 16'd5, 32'd5);
        core_we = 1'b1; core_addr = 16'd100; core_wdata = 32'd1;
        tick();
        core_wdata = 32'd2;
        tick();
        check("rdw_old", core_rdata, 32'd1);
        core_we = 1'b0;
        tick();
        check("rdw_new", core_rdata, 32'd2);
        core_we = 1'b1; core_addr = 16'd200; core_wdata = 32'h5555_5555;
        tick();
        core_we = 1'b0;
        check("oob_read", core_rdata, 32'd0);

        core_done = 1'b1;
        tick();
        check("unload_first_gap", {31'd0, out_valid}, 32'd0);
        beat = 0;
        for (int c = 0; c < 60 && beat < 8; c++) begin
            out_ready = pat[c % 4];
            if (out_valid) begin
                check($sformatf("hash_data%0d", beat), out_data, 32'h1111_1111 * 32'(beat + 1));
                check($sformatf("hash_last%0d", beat), {31'd0, out_last}, {31'd0, beat == 7});
                if (out_ready) beat++;
            end
            tick();
        end
        out_ready = 1'b0;
        check("drain_beats", 32'(beat), 32'd8);
        check("unload_idle_busy", {31'd0, busy}, 32'd0);
        check("unload_idle_valid", {31'd0, out_valid}, 32'd0);

        // 6: abort mid-load, then reload
        load_words(20, 32'hA000_0000);
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        load_words(40, 32'd0);
        wait_start("reload_core_start");
        peek(40, 16'd0,  32'd0);
        peek(40, 16'd5,  32'd5);
        peek(40, 16'd19, 32'h13);
        peek(40, 16'd39, 32'h27);
        peek(40, 16'd40, 32'h8000_0000);
        peek(40, 16'd46, 32'd0);
        peek(40, 16'd47, 32'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
